// File: rtl/fwd_scoreboard_unit.sv
// EX-stage hazard unit: operand/store-data forwarding from NUM_STG write stages and a
// completion bus, plus a scoreboard that stalls on long-latency RAW, WAW and full conditions.
module fwd_scoreboard_unit #(
   parameter int NUM_STG  = 3,
   parameter int SB_DEPTH = 4,
   parameter int AW       = 5,
   parameter int CNT_W    = 16,
   localparam int SEL_W   = $clog2(NUM_STG + 2),
   localparam int CW      = $clog2(SB_DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_STG-1:0]    stg_we,
   input  logic [NUM_STG*AW-1:0] stg_rd,
   input  logic [AW-1:0]         ex_rs1,
   input  logic [AW-1:0]         ex_rs2,
   input  logic [1:0]            ex_use,
   input  logic [AW-1:0]         me_rs2,
   input  logic                  iss_valid,
   input  logic [AW-1:0]         iss_rd,
   input  logic                  cpl_valid,
   input  logic [AW-1:0]         cpl_rd,
   output logic [SEL_W-1:0]      fwd_a,
   output logic [SEL_W-1:0]      fwd_b,
   output logic [SEL_W-1:0]      fwd_c,
   output logic                  ex_stall,
   output logic [CW-1:0]         sb_count,
   output logic                  cpl_err,
   output logic [CNT_W-1:0]      stall_cnt
);

   logic [SB_DEPTH-1:0] ent_valid;
   logic [AW-1:0]       ent_rd [SB_DEPTH];

   logic [SB_DEPTH-1:0] cpl_match;
   logic [SB_DEPTH-1:0] valid_after;
   logic [SB_DEPTH-1:0] alloc_oh;
   logic [SB_DEPTH-1:0] valid_next;
   logic [CW-1:0]       count_next;
   logic                cpl_go;
   logic                cpl_miss;
   logic                iss_go;
   logic                iss_waw;
   logic                iss_full;
   logic                iss_accept;
   logic                pend_hit;
   logic                alloc_found;

   // Scan from oldest to youngest so the lowest matching stage overwrites older ones.
   function automatic logic [SEL_W-1:0] pick_src(input logic [AW-1:0] rs, input logic en,
                                                 input int unsigned first);
      logic [SEL_W-1:0] sel;
      sel = '0;
      if (en && (rs != '0)) begin
         if (cpl_valid && (cpl_rd == rs)) sel = SEL_W'(NUM_STG + 1);
         for (int unsigned i = NUM_STG; i > first; i--) begin
            if (stg_we[i-1] && (stg_rd[(i-1)*AW +: AW] == rs)) sel = SEL_W'(i);
         end
      end
      return sel;
   endfunction

   always_comb begin
      fwd_a = pick_src(ex_rs1, ex_use[0], 0);
      fwd_b = pick_src(ex_rs2, ex_use[1], 0);
      fwd_c = pick_src(me_rs2, 1'b1, 1);
   end

   always_comb begin
      pend_hit = 1'b0;
      for (int unsigned e = 0; e < SB_DEPTH; e++) begin
         if (ent_valid[e]) begin
            if (ex_use[0] && (ex_rs1 != '0) && (ex_rs1 == ent_rd[e]) && (fwd_a == '0))
               pend_hit = 1'b1;
            if (ex_use[1] && (ex_rs2 != '0) && (ex_rs2 == ent_rd[e]) && (fwd_b == '0))
               pend_hit = 1'b1;
         end
      end
   end

   // Completion is applied before the issue checks, so a slot or rd freed this cycle
   // is immediately available to a same-cycle issue.
   always_comb begin
      cpl_go = cpl_valid && (cpl_rd != '0);
      for (int unsigned e = 0; e < SB_DEPTH; e++)
         cpl_match[e] = cpl_go && ent_valid[e] && (ent_rd[e] == cpl_rd);
      cpl_miss    = cpl_go && (cpl_match == '0);
      valid_after = ent_valid & ~cpl_match;

      iss_go  = iss_valid && (iss_rd != '0);
      iss_waw = 1'b0;
      for (int unsigned e = 0; e < SB_DEPTH; e++)
         if (valid_after[e] && (ent_rd[e] == iss_rd)) iss_waw = 1'b1;
      iss_full   = &valid_after;
      ex_stall   = pend_hit || (iss_go && (iss_full || iss_waw));
      iss_accept = iss_go && !ex_stall;

      alloc_oh    = '0;
      alloc_found = 1'b0;
      for (int unsigned e = 0; e < SB_DEPTH; e++) begin
         if (!valid_after[e] && !alloc_found) begin
            alloc_oh[e] = 1'b1;
            alloc_found = 1'b1;
         end
      end

      valid_next = valid_after | (iss_accept ? alloc_oh : '0);
      count_next = '0;
      for (int unsigned e = 0; e < SB_DEPTH; e++)
         count_next = count_next + CW'(valid_next[e]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ent_valid <= '0;
         sb_count  <= '0;
         cpl_err   <= 1'b0;
         stall_cnt <= '0;
         for (int unsigned e = 0; e < SB_DEPTH; e++) ent_rd[e] <= '0;
      end else begin
         ent_valid <= valid_next;
         sb_count  <= count_next;
         if (cpl_miss) cpl_err <= 1'b1;
         if (ex_stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
         for (int unsigned e = 0; e < SB_DEPTH; e++)
            if (iss_accept && alloc_oh[e]) ent_rd[e] <= iss_rd;
      end
   end

endmodule

// File: tb/tb_fwd_scoreboard_unit.sv
// Bench for fwd_scoreboard_unit: directed scenarios plus randomized traffic against a
// queue-based reference model of the forwarding and scoreboard rules.
module tb_fwd_scoreboard_unit;
   localparam int NUM_STG  = 3;
   localparam int SB_DEPTH = 4;
   localparam int AW       = 5;
   localparam int CNT_W    = 16;
   localparam int SEL_W    = $clog2(NUM_STG + 2);
   localparam int CW       = $clog2(SB_DEPTH + 1);
   localparam int CNT_MAX  = (1 << CNT_W) - 1;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NUM_STG-1:0]    stg_we;
   logic [NUM_STG*AW-1:0] stg_rd;
   logic [AW-1:0]         ex_rs1, ex_rs2, me_rs2, iss_rd, cpl_rd;
   logic [1:0]            ex_use;
   logic                  iss_valid, cpl_valid;
   logic [SEL_W-1:0]      fwd_a, fwd_b, fwd_c;
   logic                  ex_stall, cpl_err;
   logic [CW-1:0]         sb_count;
   logic [CNT_W-1:0]      stall_cnt;

   int errors = 0;
   int checks = 0;

   int m_pend[$];
   bit m_err;
   int m_scnt;

   always #5 clk = ~clk;

   fwd_scoreboard_unit #(.NUM_STG(NUM_STG), .SB_DEPTH(SB_DEPTH), .AW(AW), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .stg_we(stg_we), .stg_rd(stg_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
      .ex_use(ex_use), .me_rs2(me_rs2), .iss_valid(iss_valid), .iss_rd(iss_rd),
      .cpl_valid(cpl_valid), .cpl_rd(cpl_rd), .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_c(fwd_c),
      .ex_stall(ex_stall), .sb_count(sb_count), .cpl_err(cpl_err), .stall_cnt(stall_cnt));

   task automatic idle();
      rst = 1'b0; stg_we = '0; stg_rd = '0; ex_rs1 = '0; ex_rs2 = '0; ex_use = '0;
      me_rs2 = '0; iss_valid = 1'b0; iss_rd = '0; cpl_valid = 1'b0; cpl_rd = '0;
   endtask

   task automatic set_stg(input int i, input logic we, input logic [AW-1:0] rd);
      stg_we[i] = we;
      stg_rd[i*AW +: AW] = rd;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   // Reference model: youngest producer wins, then completion bus, else regfile.
   function automatic int m_sel(input logic [AW-1:0] rs, input bit en, input int first);
      if (!en || rs == 0) return 0;
      for (int i = first; i < NUM_STG; i++)
         if (stg_we[i] && stg_rd[i*AW +: AW] == rs) return i + 1;
      if (cpl_valid && cpl_rd == rs) return NUM_STG + 1;
      return 0;
   endfunction

   function automatic bit m_pending(input int r, input int skip);
      foreach (m_pend[k]) if (m_pend[k] == r && r != skip) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit m_stall();
      bit hit, freed, blocked;
      int skip;
      hit = (ex_use[0] && ex_rs1 != 0 && m_pending(int'(ex_rs1), -1) && m_sel(ex_rs1, 1'b1, 0) == 0) ||
            (ex_use[1] && ex_rs2 != 0 && m_pending(int'(ex_rs2), -1) && m_sel(ex_rs2, 1'b1, 0) == 0);
      freed = cpl_valid && cpl_rd != 0 && m_pending(int'(cpl_rd), -1);
      skip = freed ? int'(cpl_rd) : -1;
      blocked = iss_valid && iss_rd != 0 &&
                ((m_pend.size() - int'(freed)) >= SB_DEPTH || m_pending(int'(iss_rd), skip));
      return hit || blocked;
   endfunction

   task automatic m_update();
      bit st;
      bit found;
      if (rst) begin
         m_pend.delete();
         m_err = 1'b0;
         m_scnt = 0;
         return;
      end
      st = m_stall();
      if (st && m_scnt < CNT_MAX) m_scnt++;
      if (cpl_valid && cpl_rd != 0) begin
         found = 1'b0;
         for (int k = 0; k < m_pend.size(); k++) begin
            if (!found && m_pend[k] == int'(cpl_rd)) begin
               m_pend.delete(k);
               found = 1'b1;
            end
         end
         if (!found) m_err = 1'b1;
      end
      if (iss_valid && iss_rd != 0 && !st) m_pend.push_back(int'(iss_rd));
   endtask

   task automatic test_reset();
      idle();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      @(negedge clk);
      checks++; if (sb_count !== '0) begin errors++; $display("FAIL reset_sb_count: got %0d want 0", sb_count); end
      checks++; if (cpl_err !== 1'b0) begin errors++; $display("FAIL reset_cpl_err: got %0b want 0", cpl_err); end
      checks++; if (stall_cnt !== '0) begin errors++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
      checks++; if (ex_stall !== 1'b0) begin errors++; $display("FAIL reset_ex_stall: got %0b want 0", ex_stall); end
      checks++; if ({fwd_a, fwd_b, fwd_c} !== '0) begin errors++; $display("FAIL reset_fwd: got %0d/%0d/%0d want 0/0/0", fwd_a, fwd_b, fwd_c); end
   endtask

   task automatic test_forward();
      idle();
      set_stg(0, 1'b1, 5); set_stg(2, 1'b1, 5); ex_rs1 = 5; ex_use = 2'b01; ex_rs2 = 5;
      @(negedge clk);
      checks++; if (fwd_a !== 3'd1) begin errors++; $display("FAIL fwd_me_wins: got %0d want 1", fwd_a); end
      checks++; if (fwd_b !== 3'd0) begin errors++; $display("FAIL fwd_unused_b: got %0d want 0", fwd_b); end
      set_stg(0, 1'b0, 5);
      @(negedge clk);
      checks++; if (fwd_a !== 3'd3) begin errors++; $display("FAIL fwd_oldest_stage: got %0d want 3", fwd_a); end
      set_stg(2, 1'b1, 0); ex_rs1 = 0;
      @(negedge clk);
      checks++; if (fwd_a !== 3'd0) begin errors++; $display("FAIL fwd_zero_reg: got %0d want 0", fwd_a); end
      set_stg(1, 1'b1, 9); ex_rs2 = 9; ex_use = 2'b10;
      @(negedge clk);
      checks++; if (fwd_b !== 3'd2) begin errors++; $display("FAIL fwd_b_stage1: got %0d want 2", fwd_b); end
   endtask

   task automatic test_fwd_c_and_err();
      do_reset();
      set_stg(0, 1'b1, 8); set_stg(1, 1'b1, 8); me_rs2 = 8;
      @(negedge clk);
      checks++; if (fwd_c !== 3'd2) begin errors++; $display("FAIL fwd_c_skip_me: got %0d want 2", fwd_c); end
      set_stg(1, 1'b0, 8);
      @(negedge clk);
      checks++; if (fwd_c !== 3'd0) begin errors++; $display("FAIL fwd_c_me_only: got %0d want 0", fwd_c); end
      idle(); cpl_valid = 1'b1; cpl_rd = 0;
      step();
      @(negedge clk);
      checks++; if (cpl_err !== 1'b0) begin errors++; $display("FAIL cpl_rd0_no_err: got %0b want 0", cpl_err); end
      cpl_rd = 11; me_rs2 = 11;
      #1;
      checks++; if (fwd_c !== 3'd4) begin errors++; $display("FAIL fwd_c_cpl: got %0d want 4", fwd_c); end
      step();
      idle();
      @(negedge clk);
      checks++; if (cpl_err !== 1'b1) begin errors++; $display("FAIL cpl_err_set: got %0b want 1", cpl_err); end
      repeat (3) step();
      @(negedge clk);
      checks++; if (cpl_err !== 1'b1) begin errors++; $display("FAIL cpl_err_sticky: got %0b want 1", cpl_err); end
      do_reset();
      @(negedge clk);
      checks++; if (cpl_err !== 1'b0) begin errors++; $display("FAIL cpl_err_cleared: got %0b want 0", cpl_err); end
   endtask

   task automatic test_sb_basic();
      do_reset();
      iss_valid = 1'b1; iss_rd = 7;
      @(negedge clk);
      checks++; if (ex_stall !== 1'b0) begin errors++; $display("FAIL issue_no_stall: got %0b want 0", ex_stall); end
      step();
      idle(); ex_rs2 = 7; ex_use = 2'b10;
      @(negedge clk);
      checks++; if (ex_stall !== 1'b1) begin errors++; $display("FAIL raw_pending_stall: got %0b want 1", ex_stall); end
      checks++; if (sb_count !== 3'd1) begin errors++; $display("FAIL count_one: got %0d want 1", sb_count); end
      cpl_valid = 1'b1; cpl_rd = 7;
      #1;
      checks++; if (fwd_b !== 3'd4) begin errors++; $display("FAIL fwd_b_cpl: got %0d want 4", fwd_b); end
      checks++; if (ex_stall !== 1'b0) begin errors++; $display("FAIL cpl_clears_stall: got %0b want 0", ex_stall); end
      step();
      idle();
      @(negedge clk);
      checks++; if (sb_count !== 3'd0) begin errors++; $display("FAIL count_zero: got %0d want 0", sb_count); end
      checks++; if (stall_cnt !== '0) begin errors++; $display("FAIL no_stall_counted: got %0d want 0", stall_cnt); end
   endtask

   task automatic test_full();
      do_reset();
      for (int r = 1; r <= SB_DEPTH; r++) begin
         iss_valid = 1'b1; iss_rd = AW'(r);
         step();
      end
      idle();
      @(negedge clk);
      checks++; if (sb_count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d want 4", sb_count); end
      iss_valid = 1'b1; iss_rd = 9;
      #1;
      checks++; if (ex_stall !== 1'b1) begin errors++; $display("FAIL full_stall: got %0b want 1", ex_stall); end
      cpl_valid = 1'b1; cpl_rd = 2;
      #1;
      checks++; if (ex_stall !== 1'b0) begin errors++; $display("FAIL full_cpl_accept: got %0b want 0", ex_stall); end
      step();
      idle();
      @(negedge clk);
      checks++; if (sb_count !== 3'd4) begin errors++; $display("FAIL full_swap_count: got %0d want 4", sb_count); end
      ex_rs1 = 9; ex_use = 2'b01;
      #1;
      checks++; if (ex_stall !== 1'b1) begin errors++; $display("FAIL new_rd_pending: got %0b want 1", ex_stall); end
      ex_rs1 = 2;
      #1;
      checks++; if (ex_stall !== 1'b0) begin errors++; $display("FAIL freed_rd_clear: got %0b want 0", ex_stall); end
   endtask

   task automatic test_waw();
      do_reset();
      iss_valid = 1'b1; iss_rd = 6;
      step();
      @(negedge clk);
      checks++; if (ex_stall !== 1'b1) begin errors++; $display("FAIL waw_stall: got %0b want 1", ex_stall); end
      step();
      @(negedge clk);
      checks++; if (sb_count !== 3'd1) begin errors++; $display("FAIL waw_no_alloc: got %0d want 1", sb_count); end
      checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL waw_stall_cnt: got %0d want 1", stall_cnt); end
      cpl_valid = 1'b1; cpl_rd = 6;
      #1;
      checks++; if (ex_stall !== 1'b0) begin errors++; $display("FAIL waw_cpl_accept: got %0b want 0", ex_stall); end
      step();
      idle();
      @(negedge clk);
      checks++; if (sb_count !== 3'd1) begin errors++; $display("FAIL waw_count_same: got %0d want 1", sb_count); end
      ex_rs1 = 6; ex_use = 2'b01; iss_valid = 1'b1; iss_rd = 10;
      step();
      iss_valid = 1'b0; ex_rs1 = 10;
      @(negedge clk);
      checks++; if (sb_count !== 3'd1) begin errors++; $display("FAIL hit_blocks_issue: got %0d want 1", sb_count); end
      checks++; if (ex_stall !== 1'b0) begin errors++; $display("FAIL blocked_rd_untracked: got %0b want 0", ex_stall); end
      checks++; if (stall_cnt !== 16'd2) begin errors++; $display("FAIL hit_stall_cnt: got %0d want 2", stall_cnt); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int r = 3; r <= 5; r++) begin
         iss_valid = 1'b1; iss_rd = AW'(r);
         step();
      end
      idle(); ex_rs1 = 3; ex_use = 2'b01;
      step();
      step();
      idle();
      @(negedge clk);
      checks++; if (sb_count !== 3'd3) begin errors++; $display("FAIL mid_count: got %0d want 3", sb_count); end
      checks++; if (stall_cnt !== 16'd2) begin errors++; $display("FAIL mid_stall_cnt: got %0d want 2", stall_cnt); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      checks++; if (sb_count !== 3'd0) begin errors++; $display("FAIL rst_mid_count: got %0d want 0", sb_count); end
      checks++; if (stall_cnt !== '0) begin errors++; $display("FAIL rst_mid_stall_cnt: got %0d want 0", stall_cnt); end
      ex_rs1 = 3; ex_use = 2'b01;
      #1;
      checks++; if (ex_stall !== 1'b0) begin errors++; $display("FAIL rst_discards: got %0b want 0", ex_stall); end
      idle(); cpl_valid = 1'b1; cpl_rd = 4;
      step();
      idle();
      @(negedge clk);
      checks++; if (cpl_err !== 1'b1) begin errors++; $display("FAIL stale_cpl_err: got %0b want 1", cpl_err); end
   endtask

   task automatic test_random();
      int ea, eb, ec;
      bit es;
      do_reset();
      m_pend.delete(); m_err = 1'b0; m_scnt = 0;
      for (int n = 0; n < 1500; n++) begin
         stg_we = NUM_STG'($urandom);
         for (int i = 0; i < NUM_STG; i++) stg_rd[i*AW +: AW] = AW'($urandom_range(0, 9));
         ex_rs1 = AW'($urandom_range(0, 9));
         ex_rs2 = AW'($urandom_range(0, 9));
         me_rs2 = AW'($urandom_range(0, 9));
         ex_use = 2'($urandom);
         iss_valid = ($urandom_range(0, 2) == 0);
         iss_rd = AW'($urandom_range(0, 9));
         cpl_valid = ($urandom_range(0, 2) == 0);
         if (m_pend.size() > 0 && $urandom_range(0, 4) != 0)
            cpl_rd = AW'(m_pend[$urandom_range(0, m_pend.size() - 1)]);
         else
            cpl_rd = AW'($urandom_range(0, 15));
         rst = ($urandom_range(0, 99) == 0);
         @(negedge clk);
         ea = m_sel(ex_rs1, ex_use[0], 0);
         eb = m_sel(ex_rs2, ex_use[1], 0);
         ec = m_sel(me_rs2, 1'b1, 1);
         es = m_stall();
         checks++; if (fwd_a !== SEL_W'(ea)) begin errors++; $display("FAIL rnd_fwd_a @%0d: got %0d want %0d", n, fwd_a, ea); end
         checks++; if (fwd_b !== SEL_W'(eb)) begin errors++; $display("FAIL rnd_fwd_b @%0d: got %0d want %0d", n, fwd_b, eb); end
         checks++; if (fwd_c !== SEL_W'(ec)) begin errors++; $display("FAIL rnd_fwd_c @%0d: got %0d want %0d", n, fwd_c, ec); end
         checks++; if (ex_stall !== es) begin errors++; $display("FAIL rnd_ex_stall @%0d: got %0b want %0b", n, ex_stall, es); end
         checks++; if (sb_count !== CW'(m_pend.size())) begin errors++; $display("FAIL rnd_sb_count @%0d: got %0d want %0d", n, sb_count, m_pend.size()); end
         checks++; if (cpl_err !== m_err) begin errors++; $display("FAIL rnd_cpl_err @%0d: got %0b want %0b", n, cpl_err, m_err); end
         checks++; if (stall_cnt !== CNT_W'(m_scnt)) begin errors++; $display("FAIL rnd_stall_cnt @%0d: got %0d want %0d", n, stall_cnt, m_scnt); end
         m_update();
         step();
      end
      idle();
   endtask

   task automatic test_saturate();
      do_reset();
      iss_valid = 1'b1; iss_rd = 12;
      step();
      idle(); ex_rs1 = 12; ex_use = 2'b01;
      repeat (100) @(posedge clk);
      @(negedge clk);
      checks++; if (stall_cnt !== 16'd100) begin errors++; $display("FAIL stall_cnt_100: got %0d want 100", stall_cnt); end
      repeat (CNT_MAX) @(posedge clk);
      @(negedge clk);
      checks++; if (stall_cnt !== CNT_W'(CNT_MAX)) begin errors++; $display("FAIL stall_cnt_sat: got %0d want %0d", stall_cnt, CNT_MAX); end
      checks++; if (ex_stall !== 1'b1 || sb_count !== 3'd1) begin errors++; $display("FAIL sat_still_pending: got stall=%0b count=%0d want 1/1", ex_stall, sb_count); end
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (stall_cnt !== CNT_W'(CNT_MAX)) begin errors++; $display("FAIL stall_cnt_hold: got %0d want %0d", stall_cnt, CNT_MAX); end
      idle();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_forward();
      test_fwd_c_and_err();
      test_sb_basic();
      test_full();
      test_waw();
      test_reset_mid();
      test_random();
      test_saturate();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
